// File: rtl/wb_pkg.sv
// Shared definitions for the MEM/WB write-back stage: load types, FSM encoding, defaults.
package wb_pkg;

    // funct3 load encodings
    localparam logic [2:0] MT_LB  = 3'b000;
    localparam logic [2:0] MT_LH  = 3'b001;
    localparam logic [2:0] MT_LW  = 3'b010;
    localparam logic [2:0] MT_LBU = 3'b100;
    localparam logic [2:0] MT_LHU = 3'b101;

    localparam int unsigned TIMEOUT_DEF = 255;
    localparam int unsigned CNT_W       = 8;
    localparam int unsigned INSTRET_W   = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_COMMIT = 2'd2
    } wb_state_e;

endpackage

// File: rtl/load_align.sv
// Extracts and sign/zero-extends load data from an aligned memory word.
module load_align
    import wb_pkg::*;
#(
    parameter int unsigned size = 32
) (
    input  logic [size-1:0] word,
    input  logic [1:0]      addr,
    input  logic [2:0]      mem_type,
    output logic [size-1:0] data,
    output logic            misalign
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane selection by address, then extension by load type
    always_comb begin
        byte_sel = 8'h00;
        half_sel = 16'h0000;
        data     = '0;
        misalign = 1'b0;

        case (addr)
            2'd0:    byte_sel = word[7:0];
            2'd1:    byte_sel = word[15:8];
            2'd2:    byte_sel = word[23:16];
            default: byte_sel = word[31:24];
        endcase
        half_sel = addr[1] ? word[31:16] : word[15:0];

        case (mem_type)
            MT_LB:  data = {{(size-8){byte_sel[7]}}, byte_sel};
            MT_LBU: data = {{(size-8){1'b0}}, byte_sel};
            MT_LH: begin
                data     = {{(size-16){half_sel[15]}}, half_sel};
                misalign = addr[0];
            end
            MT_LHU: begin
                data     = {{(size-16){1'b0}}, half_sel};
                misalign = addr[0];
            end
            // LW and any undefined encoding
            default: begin
                data     = word;
                misalign = (addr != 2'd0);
            end
        endcase
    end

endmodule

// File: rtl/mem_wb_writeback.sv
// MEM/WB pipeline register, load-response wait FSM, register-file write port, instret.
module mem_wb_writeback
    import wb_pkg::*;
#(
    parameter int unsigned size    = 32,
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 stall_i,
    input  logic                 flush_i,
    input  logic                 valid_i,
    input  logic [4:0]           rd_i,
    input  logic                 we_i,
    input  logic                 mr_i,
    input  logic [2:0]           mem_type_i,
    input  logic [size-1:0]      result_i,
    input  logic [size-1:0]      mem_rdata_i,
    input  logic                 mem_rvalid_i,
    output logic [5:0]           Control_Signal_WB,
    output logic [size-1:0]      DATA_in_WB,
    output logic                 wb_busy_o,
    output logic                 misalign_o,
    output logic                 load_err_o,
    output logic [INSTRET_W-1:0] instret_o
);

    wb_state_e             state_q;
    logic                  valid_q;
    logic [4:0]            rd_q;
    logic                  we_q;
    logic                  mr_q;
    logic [2:0]            mem_type_q;
    logic [size-1:0]       result_q;
    logic [size-1:0]       load_buf_q;
    logic [CNT_W-1:0]      cnt_q;
    logic                  committed_q;
    logic                  misalign_q;
    logic                  load_err_q;
    logic [INSTRET_W-1:0]  instret_q;

    logic                  busy;
    logic                  capture;
    logic                  alu_commit;
    logic                  ld_commit;
    logic                  wen;
    logic                  timeout_hit;
    logic [size-1:0]       wdata;
    logic [size-1:0]       la_data;
    logic                  la_misalign;

    load_align #(.size(size)) u_load_align (
        .word     (load_buf_q),
        .addr     (result_q[1:0]),
        .mem_type (mem_type_q),
        .data     (la_data),
        .misalign (la_misalign)
    );

    // Capture decision, commit qualification and write-port data
    always_comb begin
        busy        = (state_q == ST_WAIT);
        capture     = !busy && (flush_i || !stall_i);
        alu_commit  = (state_q == ST_IDLE) && valid_q && !mr_q && !committed_q;
        ld_commit   = (state_q == ST_COMMIT) && !la_misalign;
        wen         = (alu_commit || ld_commit) && we_q && (rd_q != 5'd0);
        timeout_hit = busy && !mem_rvalid_i && (cnt_q == CNT_W'(TIMEOUT - 1));
        wdata       = '0;
        if (wen) begin
            wdata = (state_q == ST_COMMIT) ? la_data : result_q;
        end
    end

    // Stage register, FSM, timeout counter, pulses and retired-instruction count
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            valid_q     <= 1'b0;
            rd_q        <= 5'd0;
            we_q        <= 1'b0;
            mr_q        <= 1'b0;
            mem_type_q  <= 3'd0;
            result_q    <= '0;
            load_buf_q  <= '0;
            cnt_q       <= '0;
            committed_q <= 1'b0;
            misalign_q  <= 1'b0;
            load_err_q  <= 1'b0;
            instret_q   <= '0;
        end else begin
            misalign_q <= 1'b0;
            load_err_q <= 1'b0;
            if (alu_commit || ld_commit) begin
                instret_q <= instret_q + INSTRET_W'(1);
            end

            case (state_q)
                ST_IDLE, ST_COMMIT: begin
                    if (capture) begin
                        committed_q <= 1'b0;
                        cnt_q       <= '0;
                        if (flush_i) begin
                            valid_q    <= 1'b0;
                            rd_q       <= 5'd0;
                            we_q       <= 1'b0;
                            mr_q       <= 1'b0;
                            mem_type_q <= 3'd0;
                            result_q   <= '0;
                            state_q    <= ST_IDLE;
                        end else begin
                            valid_q    <= valid_i;
                            rd_q       <= rd_i;
                            we_q       <= we_i;
                            mr_q       <= mr_i;
                            mem_type_q <= mem_type_i;
                            result_q   <= result_i;
                            state_q    <= (valid_i && mr_i) ? ST_WAIT : ST_IDLE;
                        end
                    end else begin
                        // Held entry has already been dealt with; never retire it twice
                        committed_q <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    if (mem_rvalid_i) begin
                        load_buf_q <= mem_rdata_i;
                        misalign_q <= la_misalign;
                        state_q    <= ST_COMMIT;
                    end else if (timeout_hit) begin
                        load_err_q  <= 1'b1;
                        committed_q <= 1'b1;
                        state_q     <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign Control_Signal_WB = {rd_q, wen};
    assign DATA_in_WB        = wdata;
    assign wb_busy_o         = busy;
    assign misalign_o        = misalign_q;
    assign load_err_o        = load_err_q;
    assign instret_o         = instret_q;

endmodule

// File: doc/mem_wb_writeback.md
# mem_wb_writeback

Write-back stage of the 5-stage RV32I pipeline: it holds the MEM/WB pipeline register and waits for data-memory load responses. It aligns and sign-extends load data, then drives the register-file write port that the decode stage consumes (`Control_Signal_WB = {RD, WE}`, `DATA_in_WB`). While a load is outstanding it stalls the upstream pipeline, and it counts retired instructions.

## Interface
- `size`, 32: datapath width.
- `TIMEOUT`, 255: maximum cycles spent in WAIT before the load is abandoned (8-bit counter).

- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `stall_i` in 1: upstream hold; the stage register keeps its value.
- `flush_i` in 1: the stage register loads a bubble at the next capture.
- `valid_i` in 1: the incoming MEM/WB entry is a real instruction.
- `rd_i` in 5: destination register.
- `we_i` in 1: the instruction writes `rd_i`.
- `mr_i` in 1: the instruction is a load. The MEM stage folds MD into MR.
- `mem_type_i` in 3: funct3 load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- `result_i` in size: ALU result, or the effective address for loads.
- `mem_rdata_i` in size: aligned word returned by data memory.
- `mem_rvalid_i` in 1: `mem_rdata_i` is valid this cycle.
- `Control_Signal_WB` out 6: `{RD[4:0], WE}` for the register file.
- `DATA_in_WB` out size: write data.
- `wb_busy_o` out 1: stall request to upstream stages.
- `misalign_o` out 1: one-cycle pulse for a misaligned load.
- `load_err_o` out 1: one-cycle pulse for a load timeout.
- `instret_o` out 32: retired-instruction counter.

## Operation
- States:
  - IDLE: no load pending.
  - WAIT: load captured, waiting for `mem_rvalid_i`.
  - COMMIT: load data registered, write in progress.
- Capture at a clock edge happens when `wb_busy_o=0`:
  - `flush_i=1` loads a bubble (valid=0). Flush wins over stall.
  - Otherwise, `stall_i=0` loads the `*_i` inputs.
  - Otherwise (`stall_i=1`), the register holds.
- Next state after a capture: WAIT if the captured entry is valid with `mr=1`, else IDLE.
- `wb_busy_o` = (state==WAIT), combinational from the state.
- IDLE with a valid, non-load entry:
  - `WE = we & (rd!=0)`, `DATA_in_WB = result`.
  - `instret_o` increments at the edge ending the cycle. A held (stalled) entry is committed only once; an internal committed flag is cleared on the next capture.
- WAIT:
  - WE=0. The timeout counter starts at 0 on entry and increments each cycle.
  - `mem_rvalid_i=1`: register `mem_rdata_i`, go to COMMIT.
  - Counter reaches `TIMEOUT` with no `mem_rvalid_i`: pulse `load_err_o` for one cycle, go to IDLE, no write, no increment of `instret_o`.
- `mem_rvalid_i` is ignored outside WAIT.
- COMMIT (exactly one cycle):
  - Data is extracted from the registered word using `result[1:0]`:
    - LB/LBU: byte `result[1:0]`.
    - LH/LHU: half `result[1]`.
    - LW: whole word.
  - LB/LH sign-extend; LBU/LHU zero-extend.
  - Misaligned (LH/LHU with `result[0]=1`, or LW with `result[1:0]!=0`): WE=0, `misalign_o=1`, no increment of `instret_o`.
  - Otherwise: `WE = we & (rd!=0)`, and `instret_o` increments.
  - Undefined `mem_type` values are treated as LW.
- Whenever WE=0: `DATA_in_WB = 0`. `Control_Signal_WB[5:1]` always carries the registered rd.
- `instret_o` wraps from 2^32-1 to 0.
- Reset, including mid-load:
  - State IDLE, stage register is a bubble, the load buffer is cleared.
  - All outputs are 0; `instret_o=0`.

## Timing
- ALU instruction: captured at edge N; WE high during cycle N+1; the register file writes at edge N+1.
- Load:
  - Captured at edge N; WAIT from cycle N+1.
  - `mem_rvalid_i` sampled high at edge M (M ≥ N+1); COMMIT in cycle M+1; write at edge M+1.
  - Minimum load-to-write: 2 cycles.
- `wb_busy_o` drops in COMMIT, so the next entry can be captured at the end of the COMMIT cycle. Back-to-back loads do not insert an idle cycle.
- `misalign_o` and `load_err_o` are registered pulses, exactly one cycle wide.

## Structure
- Shared package `wb_pkg`: the load-type localparams (LB/LH/LW/LBU/LHU), the state encoding, and the default `TIMEOUT`.
- Sub-module `load_align`: combinational extraction and extension of load data. Its inputs are word, `addr[1:0]` and type; its outputs are data and misalign. It is reused by the memory-model testbench.
- The top level holds the stage register, the FSM, the timeout counter and `instret_o`.

## Test plan
- **ALU write:** valid, `rd=5`, `we=1`, `result=0x1234` → next cycle `Control_Signal_WB=6'b001011`, `DATA_in_WB=0x1234`, `instret_o=1`.
- **x0 and bubble:** `rd=0`, `we=1` → WE=0, `DATA_in_WB=0`, `instret_o` increments. Any entry with `flush_i=1` → no increment.
- **LB sign extension:** LB at addr `0x...3`, `mem_rdata_i=0x80FF_FF7F`, `mem_rvalid_i` 3 cycles later → `wb_busy_o` high 3 cycles; COMMIT data `0xFFFF_FF80`, WE=1.
- **LHU and misaligned LW:** LHU at addr `0x2` with `0xBEEF_0000` → `0x0000_BEEF`. LW at addr `0x1` → WE=0, `misalign_o` one-cycle pulse.
- **Timeout:** load with no `mem_rvalid_i`, `TIMEOUT=4` → `load_err_o` pulse, return to IDLE, `wb_busy_o` low, no write.
- **Reset mid-load:** assert `reset` in WAIT → all outputs 0 immediately (asynchronous). A later `mem_rvalid_i` is ignored; the next ALU instruction commits normally.
